// File: rtl/layer0_input_packer.sv
// Packs narrow feature beats into one full-width layer-0 input vector per frame.
// Frames whose last flag disagrees with the beat count are dropped and counted.
module layer0_input_packer #(
    parameter int FEAT_BITS     = 2,
    parameter int NUM_FEAT      = 48,
    parameter int FEAT_PER_BEAT = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [FEAT_PER_BEAT*FEAT_BITS-1:0] s_data,
    input  logic                              s_last,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [NUM_FEAT*FEAT_BITS-1:0]     m_data,
    output logic                              frame_err,
    output logic [7:0]                        drop_cnt
);

    localparam int BW    = FEAT_PER_BEAT * FEAT_BITS;
    localparam int VW    = NUM_FEAT * FEAT_BITS;
    localparam int BEATS = NUM_FEAT / FEAT_PER_BEAT;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

    generate
        if (NUM_FEAT % FEAT_PER_BEAT != 0) begin : g_bad_geometry
            $error("NUM_FEAT must be a multiple of FEAT_PER_BEAT");
        end
    endgenerate

    typedef enum logic {
        FILL,
        DISCARD
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   beat_cnt_reg;
    logic [VW-1:0]   asm_buf;
    logic [VW-1:0]   merged;
    logic [VW-1:0]   out_buf_reg;
    logic            out_full_reg;
    logic            frame_err_reg;
    logic [7:0]      drop_cnt_reg;

    logic at_last;
    logic beat_acc;
    logic fill_acc;
    logic wr_beat;
    logic final_ok;
    logic drop;

    assign at_last  = (beat_cnt_reg == LAST_IDX);
    assign s_ready  = (state_reg == DISCARD) || !at_last || !out_full_reg || m_ready;
    assign beat_acc = s_valid && s_ready;
    assign fill_acc = beat_acc && (state_reg == FILL);
    assign wr_beat  = fill_acc && !at_last && !s_last;
    assign final_ok = fill_acc && at_last && s_last;
    // Early last (short frame) or missing last (long frame) both drop the frame.
    assign drop     = fill_acc && (at_last ^ s_last);

    // One slot register per beat; the final beat bypasses its slot straight into out_buf.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
            logic [BW-1:0] slot_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (wr_beat && (beat_cnt_reg == CW'(gi))) begin
                    slot_reg <= s_data;
                end
            end

            assign asm_buf[gi*BW +: BW] = slot_reg;

            if (gi == BEATS - 1) begin : g_final
                assign merged[gi*BW +: BW] = s_data;
            end else begin : g_held
                assign merged[gi*BW +: BW] = slot_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= FILL;
            beat_cnt_reg  <= '0;
            out_buf_reg   <= '0;
            out_full_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            drop_cnt_reg  <= '0;
        end else begin
            frame_err_reg <= 1'b0;

            if (beat_acc) begin
                case (state_reg)
                    FILL: begin
                        if (at_last || s_last) begin
                            beat_cnt_reg <= '0;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        end
                        if (drop) begin
                            frame_err_reg <= 1'b1;
                            if (drop_cnt_reg != 8'hFF) begin
                                drop_cnt_reg <= drop_cnt_reg + 8'd1;
                            end
                        end
                        if (at_last && !s_last) begin
                            state_reg <= DISCARD;
                        end
                    end
                    DISCARD: begin
                        beat_cnt_reg <= '0;
                        if (s_last) begin
                            state_reg <= FILL;
                        end
                    end
                    default: state_reg <= FILL;
                endcase
            end

            // A new vector loading in the same cycle as a transfer keeps m_valid high.
            if (final_ok) begin
                out_buf_reg  <= merged;
                out_full_reg <= 1'b1;
            end else if (out_full_reg && m_ready) begin
                out_full_reg <= 1'b0;
            end
        end
    end

    assign m_valid   = out_full_reg;
    assign m_data    = out_buf_reg;
    assign frame_err = frame_err_reg;
    assign drop_cnt  = drop_cnt_reg;

    // Consumed bits of asm_buf are only the held slots; keep the full view referenced.
    logic unused_asm;
    assign unused_asm = ^asm_buf[VW-1 -: BW];

endmodule

// File: tb/tb_layer0_input_packer.sv
// Scoreboard bench for layer0_input_packer: expected vectors are queued when a
// clean frame is driven and compared when the packer presents them.
module tb_layer0_input_packer;

    localparam int BW = 16;
    localparam int VW = 96;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [BW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [VW-1:0] m_data;
    logic          frame_err;
    logic [7:0]    drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int err_base;

    logic [VW-1:0] exp_q[$];
    logic [BW-1:0] fr[8];
    logic [VW-1:0] vec_a, vec_b;

    layer0_input_packer dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .frame_err (frame_err),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Output monitor: pops the scoreboard on every vector transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) err_seen++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("scoreboard_nonempty", VW'(exp_q.size()), VW'(1));
                end else begin
                    logic [VW-1:0] e;
                    e = exp_q.pop_front();
                    check_val("m_data", m_data, e);
                    $display("vector out  %h", m_data);
                end
            end
        end
    end

    function automatic logic [VW-1:0] build_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < 6; k++) v[k*BW +: BW] = fr[k];
        return v;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < 8; k++) fr[k] = BW'($urandom);
    endtask

    task automatic send_beat(input logic [BW-1:0] d, input logic last);
        int waited;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        waited  = 0;
        @(negedge clk);
        while (!s_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!s_ready) check_val("s_ready_timeout", VW'(s_ready), VW'(1));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_idx, input bit push);
        if (push) exp_q.push_back(build_vec());
        for (int k = 0; k < n; k++) send_beat(fr[k], (k == last_idx));
        $display("frame in    beats=%0d last_at=%0d clean=%0d", n, last_idx, push);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int waited;
        m_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_val("drain_empty", VW'(exp_q.size()), VW'(0));
        settle();
    endtask

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        check_val("rst_m_valid", VW'(m_valid), VW'(0));
        check_val("rst_m_data", m_data, VW'(0));
        check_val("rst_frame_err", VW'(frame_err), VW'(0));
        check_val("rst_drop_cnt", VW'(drop_cnt), VW'(0));
        check_val("rst_s_ready", VW'(s_ready), VW'(1));
        @(posedge clk);
        #1;

        // Fixed-pattern frame with a single-cycle output pulse
        m_ready = 1'b1;
        err_base = err_seen;
        fr[0] = 16'h5555; fr[1] = 16'hAAAA; fr[2] = 16'h0000;
        fr[3] = 16'hFFFF; fr[4] = 16'h1234; fr[5] = 16'hC3C3;
        send_frame(6, 5, 1);
        @(negedge clk);
        check_val("t1_m_valid_rise", VW'(m_valid), VW'(1));
        check_val("t1_low_feat", VW'(m_data[15:0]), VW'(16'h5555));
        check_val("t1_high_feat", VW'(m_data[95:80]), VW'(16'hC3C3));
        @(negedge clk);
        check_val("t1_m_valid_fall", VW'(m_valid), VW'(0));
        settle();
        check_val("t1_no_err", VW'(err_seen - err_base), VW'(0));

        // Back-to-back frames against a stalled consumer
        m_ready = 1'b0;
        fill_random();
        vec_a = build_vec();
        send_frame(6, 5, 1);
        fill_random();
        vec_b = build_vec();
        for (int k = 0; k < 5; k++) send_beat(fr[k], 1'b0);
        exp_q.push_back(vec_b);
        s_data = fr[5];
        s_last = 1'b1;
        s_valid = 1'b1;
        @(negedge clk);
        check_val("t2_final_stall", VW'(s_ready), VW'(0));
        check_val("t2_hold_a", m_data, vec_a);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        check_val("t2_final_ready", VW'(s_ready), VW'(1));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        check_val("t2_valid_kept", VW'(m_valid), VW'(1));
        check_val("t2_load_b", m_data, vec_b);
        @(posedge clk);
        #1;
        drain();

        // Early last on the third beat
        do_reset();
        m_ready = 1'b1;
        err_base = err_seen;
        fill_random();
        send_frame(3, 2, 0);
        settle();
        check_val("t3_err_pulses", VW'(err_seen - err_base), VW'(1));
        check_val("t3_drop_cnt", VW'(drop_cnt), VW'(1));
        check_val("t3_no_valid", VW'(m_valid), VW'(0));
        fill_random();
        send_frame(6, 5, 1);
        drain();

        // Missing last, two trailing beats discarded
        do_reset();
        m_ready = 1'b1;
        err_base = err_seen;
        fill_random();
        send_frame(6, -1, 0);
        send_beat(16'hDEAD, 1'b0);
        send_beat(16'hBEEF, 1'b1);
        settle();
        check_val("t4_err_pulses", VW'(err_seen - err_base), VW'(1));
        check_val("t4_drop_cnt", VW'(drop_cnt), VW'(1));
        check_val("t4_no_valid", VW'(m_valid), VW'(0));
        fill_random();
        send_frame(6, 5, 1);
        drain();

        // Reset mid-frame while a vector is held
        do_reset();
        m_ready = 1'b0;
        fill_random();
        send_frame(6, 5, 1);
        fill_random();
        for (int k = 0; k < 4; k++) send_beat(fr[k], 1'b0);
        err_base = err_seen;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("t5_m_valid", VW'(m_valid), VW'(0));
        check_val("t5_drop_cnt", VW'(drop_cnt), VW'(0));
        check_val("t5_frame_err", VW'(frame_err), VW'(0));
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        fill_random();
        send_frame(6, 5, 1);
        drain();
        check_val("t5_no_err", VW'(err_seen - err_base), VW'(0));

        // Drop counter saturation
        do_reset();
        m_ready = 1'b1;
        err_base = err_seen;
        for (int i = 0; i < 260; i++) send_beat(BW'($urandom), 1'b1);
        $display("frame in    260 single-beat early-last frames");
        settle();
        check_val("t6_drop_sat", VW'(drop_cnt), VW'(255));
        check_val("t6_err_pulses", VW'(err_seen - err_base), VW'(260));
        check_val("t6_no_valid", VW'(m_valid), VW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
